// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared burst/response/state types and the WRAP mask helper
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_SLVERR = 2'd2
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WDATA,
    ST_WRESP,
    ST_RDATA
  } state_e;

  // Byte-offset bits that stay inside one WRAP window of (len+1) beats of 2**size bytes.
  function automatic logic [15:0] wrap_mask(input logic [7:0] len, input logic [2:0] size);
    logic [15:0] span;
    span = (16'(len) + 16'd1) << size;
    return span - 16'd1;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - burst address sequencer shared by the read and write paths
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 8,
  parameter int MAX_SIZE  = 2,
  parameter int MEM_BYTES = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] nxt_addr,
  output logic              nxt_ok,
  output logic              last,
  output logic              err
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [2:0]        size_q, size_d;
  burst_e            burst_q, burst_d;
  logic              perr_q, perr_d;

  logic [ADDR_W-1:0] step_bytes;
  logic [ADDR_W-1:0] mask;
  logic              wrap_ok;
  logic              size_bad;

  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    perr_d  = perr_q;

    wrap_ok  = (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
               (len == LEN_W'(7)) || (len == LEN_W'(15));
    size_bad = (size > 3'(MAX_SIZE));
    step_bytes = ADDR_W'(1) << size_q;
    mask       = ADDR_W'(wrap_mask(8'(len_q), size_q));

    if (load) begin
      addr_d = start_addr;
      cnt_d  = '0;
      len_d  = len;
      size_d = size_bad ? 3'(MAX_SIZE) : size;
      // Illegal WRAP lengths and the reserved burst code both fall back to INCR.
      if (burst == BURST_FIXED) begin
        burst_d = BURST_FIXED;
      end else if (burst == BURST_WRAP && wrap_ok) begin
        burst_d = BURST_WRAP;
      end else begin
        burst_d = BURST_INCR;
      end
      perr_d = size_bad || (burst == BURST_WRAP && !wrap_ok) || (burst == 2'b11);
    end else if (step) begin
      cnt_d = cnt_q + LEN_W'(1);
      case (burst_q)
        BURST_FIXED: addr_d = addr_q;
        BURST_WRAP:  addr_d = (addr_q & ~mask) | ((addr_q + step_bytes) & mask);
        default:     addr_d = addr_q + step_bytes;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= BURST_FIXED;
      perr_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      perr_q  <= perr_d;
    end
  end

  assign addr     = addr_q;
  assign nxt_addr = addr_d;
  assign nxt_ok   = ({1'b0, addr_d} < LIMIT);
  assign last     = (cnt_q == len_q);
  assign err      = perr_q || !({1'b0, addr_q} < LIMIT);

endmodule

// File: rtl/axi4_sram_slave_burst.sv
// rtl/axi4_sram_slave_burst.sv - single-outstanding AXI4 SRAM slave with FIXED/INCR/WRAP bursts
module axi4_sram_slave_burst
  import axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 8,
  parameter int LEN_W  = 8,
  parameter int DEPTH  = 16384
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [LEN_W-1:0]    AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [LEN_W-1:0]    ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              err_q, err_d;
  logic              lg_wr_q, lg_wr_d;
  logic              wready_q, bvalid_q, rvalid_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              aw_hs, ar_hs, w_hs;
  logic              gen_load, gen_step, mem_we, rd_issue;
  logic [ADDR_W-1:0] gen_start, gen_addr, gen_nxt_addr;
  logic [LEN_W-1:0]  gen_len;
  logic [2:0]        gen_size;
  logic [1:0]        gen_burst;
  logic              gen_nxt_ok, gen_last, gen_err;
  logic [IDX_W-1:0]  widx, ridx;
  logic              unused_addr_bits;

  // Ties go to whichever channel was not granted last; last grant resets to read.
  assign AWREADY = !ARESET && (state_q == ST_IDLE) && AWVALID && (!ARVALID || !lg_wr_q);
  assign ARREADY = !ARESET && (state_q == ST_IDLE) && ARVALID && (!AWVALID || lg_wr_q);

  assign aw_hs = AWVALID && AWREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign w_hs  = WVALID && wready_q;

  assign gen_load  = aw_hs || ar_hs;
  assign gen_start = aw_hs ? AWADDR  : ARADDR;
  assign gen_len   = aw_hs ? AWLEN   : ARLEN;
  assign gen_size  = aw_hs ? AWSIZE  : ARSIZE;
  assign gen_burst = aw_hs ? AWBURST : ARBURST;

  axi_burst_addr_gen #(
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .MAX_SIZE  (OFF_W),
    .MEM_BYTES (DEPTH * BYTES)
  ) u_addr_gen (
    .clk        (ACLK),
    .rst        (ARESET),
    .load       (gen_load),
    .step       (gen_step),
    .start_addr (gen_start),
    .len        (gen_len),
    .size       (gen_size),
    .burst      (gen_burst),
    .addr       (gen_addr),
    .nxt_addr   (gen_nxt_addr),
    .nxt_ok     (gen_nxt_ok),
    .last       (gen_last),
    .err        (gen_err)
  );

  assign widx = gen_addr[IDX_W+OFF_W-1:OFF_W];
  assign ridx = gen_nxt_addr[IDX_W+OFF_W-1:OFF_W];
  assign unused_addr_bits = ^{gen_addr, gen_nxt_addr};

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    err_d    = err_q;
    lg_wr_d  = lg_wr_q;
    gen_step = 1'b0;
    mem_we   = 1'b0;
    rd_issue = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          id_d    = AWID;
          err_d   = 1'b0;
          lg_wr_d = 1'b1;
          state_d = ST_WDATA;
        end else if (ar_hs) begin
          id_d     = ARID;
          err_d    = 1'b0;
          lg_wr_d  = 1'b0;
          rd_issue = 1'b1;
          state_d  = ST_RDATA;
        end
      end
      ST_WDATA: begin
        if (w_hs) begin
          mem_we = !gen_err;
          // The beat counter decides burst end; a disagreeing WLAST only flags SLVERR.
          err_d  = err_q || gen_err || (WLAST != gen_last);
          if (gen_last) begin
            state_d = ST_WRESP;
          end else begin
            gen_step = 1'b1;
          end
        end
      end
      ST_WRESP: begin
        if (BREADY) begin
          state_d = ST_IDLE;
        end
      end
      ST_RDATA: begin
        if (RREADY) begin
          err_d = err_q || gen_err;
          if (gen_last) begin
            state_d = ST_IDLE;
          end else begin
            gen_step = 1'b1;
            rd_issue = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data is fetched on the address/handshake cycle so the next beat is ready one edge later.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_issue) begin
      rdata_d = gen_nxt_ok ? mem[ridx] : '0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= ST_IDLE;
      id_q     <= '0;
      err_q    <= 1'b0;
      lg_wr_q  <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      err_q    <= err_d;
      lg_wr_q  <= lg_wr_d;
      wready_q <= (state_d == ST_WDATA);
      bvalid_q <= (state_d == ST_WRESP);
      rvalid_q <= (state_d == ST_RDATA);
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (WSTRB[b]) begin
          mem[widx][b*8 +: 8] <= WDATA[b*8 +: 8];
        end
      end
    end
  end

  assign WREADY = wready_q;
  assign BVALID = bvalid_q;
  assign BID    = id_q;
  assign BRESP  = (bvalid_q && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign RVALID = rvalid_q;
  assign RID    = id_q;
  assign RDATA  = rdata_q;
  assign RLAST  = rvalid_q && gen_last;
  assign RRESP  = (rvalid_q && (err_q || gen_err)) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi4_sram_slave_burst.sv
// tb/tb_axi4_sram_slave_burst.sv - directed bench for the AXI4 SRAM burst slave
module tb_axi4_sram_slave_burst;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] wdat   [16];
  logic [31:0] rexp   [16];
  logic [1:0]  rrespx [16];

  always #5 ACLK = ~ACLK;

  axi4_sram_slave_burst dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int k;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = burst; AWVALID = 1'b1;
    #1;
    k = 0;
    while (AWREADY !== 1'b1 && k < 40) begin @(negedge ACLK); #1; k++; end
    chk("awready", AWREADY, 1'b1);
    @(negedge ACLK);
    AWVALID = 1'b0;
    chk("wready_latency", WREADY, 1'b1);
  endtask

  task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int k;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = burst; ARVALID = 1'b1;
    #1;
    k = 0;
    while (ARREADY !== 1'b1 && k < 40) begin @(negedge ACLK); #1; k++; end
    chk("arready", ARREADY, 1'b1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    chk("rvalid_latency", RVALID, 1'b1);
  endtask

  task automatic w_burst(input int n, input logic [3:0] strb, input int last_idx);
    int k;
    for (int i = 0; i < n; i++) begin
      WDATA = wdat[i]; WSTRB = strb; WLAST = (i == last_idx); WVALID = 1'b1;
      #1;
      k = 0;
      while (WREADY !== 1'b1 && k < 40) begin @(negedge ACLK); #1; k++; end
      chk("wready", WREADY, 1'b1);
      @(negedge ACLK);
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
  endtask

  task automatic b_check(input logic [7:0] id, input logic [1:0] resp);
    int k;
    chk("bvalid_latency", BVALID, 1'b1);
    BREADY = 1'b1;
    k = 0;
    while (BVALID !== 1'b1 && k < 40) begin @(negedge ACLK); k++; end
    chk("bid", BID, id);
    chk("bresp", BRESP, resp);
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic r_burst(input int n, input logic [7:0] id);
    int k;
    RREADY = 1'b1;
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (RVALID !== 1'b1 && k < 40) begin @(negedge ACLK); k++; end
      chk("rvalid", RVALID, 1'b1);
      chk("rid", RID, id);
      chk("rdata", RDATA, rexp[i]);
      chk("rresp", RRESP, rrespx[i]);
      chk("rlast", RLAST, (i == n - 1));
      @(negedge ACLK);
    end
    RREADY = 1'b0;
  endtask

  task automatic full_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] strb, input int last_idx,
                            input logic [1:0] resp);
    aw_send(id, addr, len, burst);
    w_burst(int'(len) + 1, strb, last_idx);
    b_check(id, resp);
  endtask

  task automatic full_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
    ar_send(id, addr, len, burst);
    r_burst(int'(len) + 1, id);
  endtask

  task automatic resp_all_okay();
    for (int i = 0; i < 16; i++) rrespx[i] = 2'b00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b0;
    resp_all_okay();
    repeat (3) @(negedge ACLK);

    chk("rst_awready", AWREADY, 1'b0);
    chk("rst_arready", ARREADY, 1'b0);
    chk("rst_wready",  WREADY,  1'b0);
    chk("rst_bvalid",  BVALID,  1'b0);
    chk("rst_rvalid",  RVALID,  1'b0);
    chk("rst_rlast",   RLAST,   1'b0);
    chk("rst_bid",     BID,     8'h00);
    chk("rst_bresp",   BRESP,   2'b00);
    chk("rst_rid",     RID,     8'h00);
    chk("rst_rresp",   RRESP,   2'b00);
    chk("rst_rdata",   RDATA,   32'h0);
    ARESET = 1'b0;
    @(negedge ACLK);

    // Simultaneous AW/AR from reset: write wins, then read wins the next tie.
    AWID = 8'h01; AWADDR = 32'h400; AWLEN = 8'd0; AWSIZE = 3'd2; AWBURST = 2'd1; AWVALID = 1'b1;
    ARID = 8'h02; ARADDR = 32'h400; ARLEN = 8'd0; ARSIZE = 3'd2; ARBURST = 2'd1; ARVALID = 1'b1;
    #1;
    chk("tie1_awready", AWREADY, 1'b1);
    chk("tie1_arready", ARREADY, 1'b0);
    @(negedge ACLK);
    AWVALID = 1'b0;
    #1;
    chk("tie1_arready_busy", ARREADY, 1'b0);
    wdat[0] = 32'h1111_1111;
    w_burst(1, 4'hF, 0);
    b_check(8'h01, 2'b00);
    AWID = 8'h03; AWADDR = 32'h404; AWVALID = 1'b1;
    #1;
    chk("tie2_arready", ARREADY, 1'b1);
    chk("tie2_awready", AWREADY, 1'b0);
    @(negedge ACLK);
    ARVALID = 1'b0;
    chk("tie2_rvalid_latency", RVALID, 1'b1);
    rexp[0] = 32'h1111_1111;
    r_burst(1, 8'h02);
    #1;
    chk("tie2_aw_after_read", AWREADY, 1'b1);
    @(negedge ACLK);
    AWVALID = 1'b0;
    wdat[0] = 32'h2222_2222;
    w_burst(1, 4'hF, 0);
    b_check(8'h03, 2'b00);

    // W presented without an address must not be accepted.
    WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("w_before_aw", WREADY, 1'b0);
    end
    WVALID = 1'b0; WLAST = 1'b0;

    // INCR write 0x100 then readback.
    for (int i = 0; i < 4; i++) wdat[i] = 32'hA0 + i;
    full_write(8'h10, 32'h100, 8'd3, 2'd1, 4'hF, 3, 2'b00);
    for (int i = 0; i < 4; i++) rexp[i] = 32'hA0 + i;
    full_read(8'h11, 32'h100, 8'd3, 2'd1);

    // WRAP read from 0x38 over 0x30..0x3C.
    for (int i = 0; i < 4; i++) wdat[i] = 32'hB0 + i;
    full_write(8'h12, 32'h30, 8'd3, 2'd1, 4'hF, 3, 2'b00);
    rexp[0] = 32'hB2; rexp[1] = 32'hB3; rexp[2] = 32'hB0; rexp[3] = 32'hB1;
    full_read(8'h13, 32'h38, 8'd3, 2'd2);

    // Byte strobes.
    wdat[0] = 32'hFFFF_FFFF;
    full_write(8'h14, 32'h200, 8'd0, 2'd1, 4'hF, 0, 2'b00);
    wdat[0] = 32'hDDCC_BBAA;
    full_write(8'h15, 32'h200, 8'd0, 2'd1, 4'h5, 0, 2'b00);
    rexp[0] = 32'hFFCC_FFAA;
    full_read(8'h16, 32'h200, 8'd0, 2'd1);

    // Out of range INCR write from the last word.
    wdat[0] = 32'h5A5A_5A5A;
    full_write(8'h17, 32'h0, 8'd0, 2'd1, 4'hF, 0, 2'b00);
    wdat[0] = 32'hC0; wdat[1] = 32'hC1;
    full_write(8'h18, 32'hFFFC, 8'd1, 2'd1, 4'hF, 1, 2'b10);
    rexp[0] = 32'hC0; rexp[1] = 32'h0; rrespx[1] = 2'b10;
    full_read(8'h19, 32'hFFFC, 8'd1, 2'd1);
    resp_all_okay();
    rexp[0] = 32'h5A5A_5A5A;
    full_read(8'h1A, 32'h0, 8'd0, 2'd1);

    // WLAST early: counter still rules, response is SLVERR, both beats land.
    wdat[0] = 32'h60; wdat[1] = 32'h61;
    full_write(8'h1B, 32'h600, 8'd1, 2'd1, 4'hF, 0, 2'b10);
    rexp[0] = 32'h60; rexp[1] = 32'h61;
    full_read(8'h1C, 32'h600, 8'd1, 2'd1);

    // FIXED burst overwrites the same word; illegal WRAP length flags SLVERR.
    wdat[0] = 32'hD0; wdat[1] = 32'hD1;
    full_write(8'h1D, 32'h500, 8'd1, 2'd0, 4'hF, 1, 2'b00);
    rexp[0] = 32'hD1; rexp[1] = 32'hD1;
    full_read(8'h1E, 32'h500, 8'd1, 2'd0);
    rexp[0] = 32'hA0; rexp[1] = 32'hA1; rexp[2] = 32'hA2;
    for (int i = 0; i < 3; i++) rrespx[i] = 2'b10;
    full_read(8'h1F, 32'h100, 8'd2, 2'd2);
    resp_all_okay();

    // Backpressure on the second beat of a 4-beat read.
    ar_send(8'h20, 32'h100, 8'd3, 2'd1);
    RREADY = 1'b1;
    chk("stall_b0", RDATA, 32'hA0);
    @(negedge ACLK);
    RREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("stall_rvalid", RVALID, 1'b1);
      chk("stall_rdata", RDATA, 32'hA1);
      chk("stall_rlast", RLAST, 1'b0);
      chk("stall_rresp", RRESP, 2'b00);
    end
    rexp[0] = 32'hA1; rexp[1] = 32'hA2; rexp[2] = 32'hA3;
    r_burst(3, 8'h20);
    chk("stall_idle_after", RVALID, 1'b0);

    // Reset in the middle of a write keeps the beats already taken.
    for (int i = 0; i < 4; i++) wdat[i] = 32'hE0 + i;
    aw_send(8'h21, 32'h300, 8'd3, 2'd1);
    w_burst(2, 4'hF, 7);
    ARESET = 1'b1;
    #1;
    chk("wabort_wready", WREADY, 1'b0);
    chk("wabort_bvalid", BVALID, 1'b0);
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    rexp[0] = 32'hE0; rexp[1] = 32'hE1;
    full_read(8'h22, 32'h300, 8'd1, 2'd1);

    // Reset in the middle of a read.
    ar_send(8'h23, 32'h100, 8'd3, 2'd1);
    RREADY = 1'b1;
    @(negedge ACLK);
    chk("rabort_beat1", RDATA, 32'hA1);
    RREADY = 1'b0;
    ARESET = 1'b1;
    #1;
    chk("rabort_rvalid", RVALID, 1'b0);
    chk("rabort_rdata",  RDATA,  32'h0);
    chk("rabort_rlast",  RLAST,  1'b0);
    chk("rabort_rid",    RID,    8'h00);
    chk("rabort_rresp",  RRESP,  2'b00);
    @(posedge ACLK);
    #1;
    chk("rabort_rvalid_edge", RVALID, 1'b0);
    chk("rabort_arready",     ARREADY, 1'b0);
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    rexp[0] = 32'hA0;
    full_read(8'h24, 32'h100, 8'd0, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
